// File: rtl/dbu_pkg.sv
// Shared state encoding and constants for the DBU run/step controller.
package dbu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/dbu_run_ctrl_if.sv
// Board-side signal bundle of the DBU run/step controller.
interface dbu_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              succ;
    logic              step;
    logic              inc;
    logic              dec;
    logic              m_rf;
    logic              cpu_en;
    logic [ADDR_W-1:0] addr;
    logic              run_led;
    logic [CNT_W-1:0]  cyc_cnt;

    modport master (
        output succ, step, inc, dec, m_rf,
        input  cpu_en, addr, run_led, cyc_cnt
    );

    modport slave (
        input  succ, step, inc, dec, m_rf,
        output cpu_en, addr, run_led, cyc_cnt
    );
endinterface

// File: rtl/dbu_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted 0->1 transition of the debounced level.
module dbu_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic pulse
);

    localparam int             CW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          s;

    assign s = sync_q[1];

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            pulse  <= 1'b0;
            if (s == level) begin
                cnt_q <= '0;
            end else if (cnt_q == C_LAST) begin
                // Disagreement has lasted DEB_CYCLES samples: accept the new level.
                level <= s;
                pulse <= s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbu_run_ctrl.sv
// DBU run/step sequencer: gates the CPU clock-enable, tracks the displayed
// regfile/memory address and counts enabled CPU cycles.
module dbu_run_ctrl
    import dbu_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    dbu_run_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] RF_MASK = ADDR_W'((1 << RF_ADDR_W) - 1);

    logic [1:0]        succ_sync_q;
    logic [1:0]        m_rf_sync_q;
    logic              m_rf_prev_q;
    logic              succ_s;
    logic              m_rf_s;
    logic              m_rf_chg;
    logic              step_level;
    logic              step_pulse;
    logic              inc_level;
    logic              inc_pulse;
    logic              dec_level;
    logic              dec_pulse;
    logic              unused_levels;
    state_t            state_q;
    state_t            state_d;
    logic              cpu_en;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  cnt_q;

    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.step),
        .level(step_level),
        .pulse(step_pulse)
    );

    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.inc),
        .level(inc_level),
        .pulse(inc_pulse)
    );

    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.dec),
        .level(dec_level),
        .pulse(dec_pulse)
    );

    assign unused_levels = inc_level ^ dec_level;

    // succ and m_rf are switches: synchronised only, never debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            succ_sync_q <= '0;
            m_rf_sync_q <= '0;
            m_rf_prev_q <= 1'b0;
        end else begin
            succ_sync_q <= {succ_sync_q[0], bus.succ};
            m_rf_sync_q <= {m_rf_sync_q[0], bus.m_rf};
            m_rf_prev_q <= m_rf_sync_q[1];
        end
    end

    assign succ_s   = succ_sync_q[1];
    assign m_rf_s   = m_rf_sync_q[1];
    assign m_rf_chg = m_rf_s ^ m_rf_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (succ_s) begin
                    state_d = ST_RUN;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!succ_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Wait for the button to be released so one press is one step.
                if (succ_s) begin
                    state_d = ST_RUN;
                end else if (!step_level) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state_q is cleared asynchronously, so cpu_en falls with rst_n, not at a clock edge.
    assign cpu_en = (state_q == ST_RUN) || (state_q == ST_STEP);

    always_comb begin
        addr_d = addr_q;
        if (m_rf_chg) begin
            addr_d = '0;
        end else if (inc_pulse != dec_pulse) begin
            addr_d = inc_pulse ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
            if (!m_rf_s) begin
                addr_d = addr_d & RF_MASK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            if (cpu_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.cpu_en  = cpu_en;
    assign bus.addr    = addr_q;
    assign bus.run_led = (state_q == ST_RUN);
    assign bus.cyc_cnt = cnt_q;

endmodule

// File: tb/tb_dbu_run_ctrl.sv
// Scoreboard bench for dbu_run_ctrl: stimulus queues expected events and
// snapshots, monitors compare them as the DUT produces them.
module tb_dbu_run_ctrl;

    typedef enum logic [1:0] {EV_NONE, EV_CPU, EV_ADDR, EV_SNAP} ev_t;

    typedef struct packed {
        ev_t         kind;
        logic        cpu_en;
        logic        run_led;
        logic [7:0]  addr;
        logic [15:0] cnt;
    } obs_t;

    logic clk;
    logic rst_n;

    dbu_run_ctrl_if #(.ADDR_W(8), .CNT_W(16)) bus ();

    dbu_run_ctrl #(.DEB_CYCLES(4), .ADDR_W(8), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total = 0;
    int          bad   = 0;
    obs_t        exp_q[$];
    obs_t        snap_q[$];
    string       snap_name_q[$];
    logic [15:0] exp_cnt = '0;
    logic [7:0]  prev_addr = '0;
    event        snap_ev;

    function automatic obs_t mk(ev_t k, logic c, logic r, logic [7:0] a, logic [15:0] n);
        obs_t o;
        o.kind    = k;
        o.cpu_en  = c;
        o.run_led = r;
        o.addr    = a;
        o.cnt     = n;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got kind=%0d cpu_en=%0b run_led=%0b addr=%0d cyc_cnt=%0d, want kind=%0d cpu_en=%0b run_led=%0b addr=%0d cyc_cnt=%0d",
                     name, act.kind, act.cpu_en, act.run_led, act.addr, act.cnt,
                     exp.kind, exp.cpu_en, exp.run_led, exp.addr, exp.cnt);
        end
    endtask

    task automatic expect_evt(input string name, input obs_t o);
        obs_t e;
        if (exp_q.size() == 0) begin
            check({"unexpected ", name}, o, '0);
        end else begin
            e = exp_q.pop_front();
            check(name, o, e);
        end
    endtask

    // Event monitor: every enabled CPU cycle and every address change is an output event.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_addr = '0;
        end else begin
            if (bus.cpu_en === 1'b1) begin
                expect_evt("cpu_en cycle", mk(EV_CPU, 1'b1, bus.run_led, 8'd0, bus.cyc_cnt));
            end
            if (bus.addr !== prev_addr) begin
                expect_evt("addr change", mk(EV_ADDR, 1'b0, 1'b0, bus.addr, 16'd0));
            end
            prev_addr = bus.addr;
        end
    end

    // Snapshot monitor: full output state at instants chosen by the stimulus.
    always begin
        obs_t  o;
        obs_t  e;
        string n;
        @(snap_ev);
        o = mk(EV_SNAP, bus.cpu_en, bus.run_led, bus.addr, bus.cyc_cnt);
        if (snap_q.size() == 0) begin
            check("unexpected snapshot", o, '0);
        end else begin
            e = snap_q.pop_front();
            n = snap_name_q.pop_front();
            check(n, o, e);
        end
    end

    task automatic snap(input string name, input logic c, input logic r,
                        input logic [7:0] a, input logic [15:0] n);
        snap_q.push_back(mk(EV_SNAP, c, r, a, n));
        snap_name_q.push_back(name);
        ->snap_ev;
        #1;
    endtask

    task automatic push_cpu(input logic r);
        exp_q.push_back(mk(EV_CPU, 1'b1, r, 8'd0, exp_cnt));
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic push_addr(input logic [7:0] a);
        exp_q.push_back(mk(EV_ADDR, 1'b0, 1'b0, a, 16'd0));
    endtask

    // which: 0 = step, 1 = inc, 2 = dec, 3 = inc and dec together
    task automatic press(input int which, input int hold);
        case (which)
            0:       bus.step = 1'b1;
            1:       bus.inc  = 1'b1;
            2:       bus.dec  = 1'b1;
            default: begin
                bus.inc = 1'b1;
                bus.dec = 1'b1;
            end
        endcase
        repeat (hold) @(posedge clk);
        #1;
        bus.step = 1'b0;
        bus.inc  = 1'b0;
        bus.dec  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1, "time limit expired");
    end

    initial begin
        logic [15:0] base;
        obs_t        e;

        bus.succ = 1'b0;
        bus.step = 1'b0;
        bus.inc  = 1'b0;
        bus.dec  = 1'b0;
        bus.m_rf = 1'b0;
        rst_n    = 1'b1;

        // 1. reset
        #1 rst_n = 1'b0;
        #2 snap("reset asserted", 1'b0, 1'b0, 8'd0, 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        snap("after reset", 1'b0, 1'b0, 8'd0, 16'd0);

        // 2. single step and a short glitch
        push_cpu(1'b0);
        press(0, 10);
        snap("single step", 1'b0, 1'b0, 8'd0, exp_cnt);
        press(0, 2);
        snap("step glitch", 1'b0, 1'b0, 8'd0, exp_cnt);

        // 3. continuous run for 20 synced cycles, with a step press inside it
        base = exp_cnt;
        for (int i = 0; i < 20; i++) push_cpu(1'b1);
        bus.succ = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        snap("run in progress", 1'b1, 1'b1, 8'd0, base + 16'd7);
        bus.step = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.step = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.succ = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        snap("run finished", 1'b0, 1'b0, 8'd0, exp_cnt);

        // 4. address wrap in both spaces
        for (int i = 0; i < 33; i++) begin
            push_addr(8'((i + 1) % 32));
            press(1, 6);
        end
        push_addr(8'd0);
        press(2, 6);
        push_addr(8'd31);
        press(2, 6);
        snap("rf wrap down", 1'b0, 1'b0, 8'd31, exp_cnt);
        push_addr(8'd0);
        bus.m_rf = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        push_addr(8'd255);
        press(2, 6);
        snap("mem wrap down", 1'b0, 1'b0, 8'd255, exp_cnt);

        // 5. simultaneous inc/dec, then a space switch clears the address
        press(3, 6);
        snap("inc and dec together", 1'b0, 1'b0, 8'd255, exp_cnt);
        for (int i = 0; i < 8; i++) begin
            push_addr(8'(i));
            press(1, 6);
        end
        snap("mem addr 7", 1'b0, 1'b0, 8'd7, exp_cnt);
        push_addr(8'd0);
        bus.m_rf = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        snap("m_rf switch clears", 1'b0, 1'b0, 8'd0, exp_cnt);
        for (int i = 1; i <= 3; i++) begin
            push_addr(8'(i));
            press(1, 6);
        end

        // 6. asynchronous reset in the middle of a run
        for (int i = 0; i < 3; i++) push_cpu(1'b1);
        bus.succ = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n    = 1'b0;
        bus.succ = 1'b0;
        #1;
        snap("reset mid-run", 1'b0, 1'b0, 8'd0, 16'd0);
        exp_cnt = '0;
        #8 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        snap("idle after reset", 1'b0, 1'b0, 8'd0, 16'd0);
        push_cpu(1'b0);
        press(0, 6);
        snap("step after reset", 1'b0, 1'b0, 8'd0, exp_cnt);

        repeat (5) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed event: got nothing, want kind=%0d run_led=%0b addr=%0d cyc_cnt=%0d",
                     e.kind, e.run_led, e.addr, e.cnt);
        end
        while (snap_q.size() > 0) begin
            e = snap_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed snapshot: got nothing, want addr=%0d cyc_cnt=%0d", e.addr, e.cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
